// File: rtl/load_store_unit_if.sv
// load_store_unit_if: execute request, data-memory handshake and writeback bundle for the LSU.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;
  modport master (
    input  req_valid, req_load, req_funct3, req_addr, req_wdata, req_rd, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be, wb_valid, wb_rd, wb_data,
           misalign, bus_err
  );
  modport slave (
    output req_valid, req_load, req_funct3, req_addr, req_wdata, req_rd, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be, wb_valid, wb_rd, wb_data,
           misalign, bus_err
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: one load/store at a time over a variable-latency memory handshake,
// with alignment checks, ack timeout and aligned/extended single-cycle load writeback.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  load_store_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WB, ERR} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t      r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic        r_load, r_bus_err, r_mem_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [4:0]  r_rd, r_wb_rd;
  logic [31:0] r_wb_data, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        w_accept, w_illegal, w_timeout, w_ack;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext, w_lane;
  logic [3:0]  w_be;
  assign bus.req_ready = rst & (r_state == IDLE);
  assign bus.mem_req   = r_state == REQ;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.misalign  = r_state == ERR;
  assign bus.bus_err   = r_bus_err;
  assign bus.wb_valid  = (r_state == WB) && (r_wb_rd != 5'd0);
  assign bus.wb_rd     = r_wb_rd;
  assign bus.wb_data   = r_wb_data;
  assign w_accept  = bus.req_valid & bus.req_ready;
  assign w_ack     = (r_state == REQ) & bus.mem_ack;
  assign w_timeout = (r_state == REQ) && !bus.mem_ack && (r_cnt == CW'(TIMEOUT - 1));
  always_comb begin
    w_illegal = bus.req_load
      ? (bus.req_funct3 == 3'd3 || bus.req_funct3 >= 3'd6 ||
         (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) ||
         (bus.req_funct3 == 3'd2 && bus.req_addr[1:0] != 2'd0))
      : (bus.req_funct3 >= 3'd3 ||
         (bus.req_funct3 == 3'd1 && bus.req_addr[0]) ||
         (bus.req_funct3 == 3'd2 && bus.req_addr[1:0] != 2'd0));
    w_lane = bus.req_funct3[1:0] == 2'd0 ? {4{bus.req_wdata[7:0]}} :
             bus.req_funct3[1:0] == 2'd1 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
    w_be = bus.req_load ? 4'b0000 :
           bus.req_funct3[1:0] == 2'd0 ? 4'b0001 << bus.req_addr[1:0] :
           bus.req_funct3[1:0] == 2'd1 ? 4'b0011 << bus.req_addr[1:0] : 4'b1111;
    w_byte = bus.mem_rdata[8*r_off +: 8];
    w_half = bus.mem_rdata[16*r_off[1] +: 16];
    w_ext = r_funct3[1:0] == 2'd0 ? {{24{w_byte[7] & ~r_funct3[2]}}, w_byte} :
            r_funct3[1:0] == 2'd1 ? {{16{w_half[15] & ~r_funct3[2]}}, w_half} : bus.mem_rdata;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? (w_illegal ? ERR : REQ) : IDLE;
      REQ:     w_next = w_ack ? (r_load ? WB : IDLE) : (w_timeout ? IDLE : REQ);
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_load      <= 1'b0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_rd        <= 5'd0;
      r_bus_err   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'd0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= 32'd0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= (r_state == REQ && !bus.mem_ack) ? r_cnt + 1'b1 : '0;
      r_bus_err <= w_timeout;
      if (w_accept) begin
        r_load      <= bus.req_load;
        r_funct3    <= bus.req_funct3;
        r_off       <= bus.req_addr[1:0];
        r_rd        <= bus.req_rd;
        r_mem_we    <= ~bus.req_load;
        r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
        r_mem_wdata <= w_lane;
        r_mem_be    <= w_be;
      end
      if (w_ack && r_load) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= w_ext;
      end
    end
  end
endmodule
